// File: rtl/mul_err_eval_ctrl.sv
// mul_err_eval_ctrl
//   Sequencer for characterising an 8x8 approximate multiplier. For each
//   operand pair it drives mul_a/mul_b, waits SETTLE_CYCLES, samples mul_o,
//   and compares it with the exact product. Across the run it accumulates the
//   error count, the sum of absolute error distance and the maximum absolute
//   error distance.
//
//   Ports
//     clk, rst_n          clock (rising edge), async active-low reset
//     start               run request, only looked at in IDLE
//     mul_a, mul_b        operands to the multiplier under test
//     mul_o               approximate product from the multiplier under test
//     busy                high from LOAD through DONE
//     done                one-cycle pulse when the last sample is evaluated
//     sample_idx          samples evaluated in the current/last run
//     err_count           samples where mul_o differed from the exact product
//     sum_ed_abs          sum of |exact - mul_o|
//     max_ed              max of |exact - mul_o|
//
//   Optional build macro
//     EXHAUSTIVE_SWEEP_EN  operands come from a {A,B} counter starting at 0 and
//                          every one of the 65536 pairs is evaluated once;
//                          N_SAMPLES and LFSR_SEED are then unused.
module mul_err_eval_ctrl #(
  parameter int          N_SAMPLES     = 10000,
  parameter int          SETTLE_CYCLES = 62,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_o,
  output logic        busy,
  output logic        done,
  output logic [16:0] sample_idx,
  output logic [16:0] err_count,
  output logic [31:0] sum_ed_abs,
  output logic [15:0] max_ed
);

  // Counter only has to hold SETTLE_CYCLES-1.
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

`ifdef EXHAUSTIVE_SWEEP_EN
  localparam logic [15:0] GEN_SEED = 16'h0000;
  localparam logic [16:0] N_LAST   = 17'h10000;
`else
  localparam logic [15:0] GEN_SEED = LFSR_SEED;
  localparam logic [16:0] N_LAST   = 17'(N_SAMPLES);
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_EVAL, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  settle_cnt;
  logic [15:0]    gen;       // operand source: LFSR or sweep counter
  logic [15:0]    gen_nxt;
  logic [15:0]    exact;
  logic [15:0]    ed;
  logic [16:0]    idx_nxt;
  logic           last;

  // Operand source step, used once per sample in EVAL.
`ifdef EXHAUSTIVE_SWEEP_EN
  assign gen_nxt = gen + 16'd1;
`else
  // Galois right-shift LFSR, taps 16'hB400.
  assign gen_nxt = gen[0] ? ((gen >> 1) ^ 16'hB400) : (gen >> 1);
`endif

  assign exact   = 16'(mul_a) * 16'(mul_b);
  assign ed      = (exact >= mul_o) ? (exact - mul_o) : (mul_o - exact);
  assign idx_nxt = sample_idx + 17'd1;
  assign last    = (idx_nxt == N_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == '0) state_nxt = S_EVAL;
      S_EVAL:   state_nxt = last ? S_DONE : S_LOAD;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a      <= '0;
      mul_b      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sample_idx <= '0;
      err_count  <= '0;
      sum_ed_abs <= '0;
      max_ed     <= '0;
      settle_cnt <= '0;
      gen        <= GEN_SEED;
    end else begin
      unique case (state)
        S_IDLE: begin
          // Previous results stay visible until the next run is requested.
          if (start) begin
            busy       <= 1'b1;
            sample_idx <= '0;
            err_count  <= '0;
            sum_ed_abs <= '0;
            max_ed     <= '0;
            gen        <= GEN_SEED;
          end
        end
        S_LOAD: begin
          mul_a      <= gen[15:8];
          mul_b      <= gen[7:0];
          settle_cnt <= SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        S_EVAL: begin
          sample_idx <= idx_nxt;
          if (ed != 16'd0) err_count <= err_count + 17'd1;
          // 65535 * 65536 fits in 32 bits, so no saturation is needed.
          sum_ed_abs <= sum_ed_abs + 32'(ed);
          if (ed > max_ed) max_ed <= ed;
          gen        <= gen_nxt;
          // Registered so the pulse coincides with the DONE state.
          if (last) done <= 1'b1;
        end
        S_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
